// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle for seq_restoring_divider.
// master: start, dividend, divisor out; slave: busy, done, quotient, remainder, div_by_zero out.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async active-low), bus (slave: start/operands in, busy/done/results out).
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_sr;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   r;
    logic [CW-1:0]    count;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   s;
    logic [WIDTH:0]   next_r;
    logic [WIDTH-1:0] next_q;
    logic             last;
    // The partial remainder's top bit is always 0 after a restore step,
    // so only its low WIDTH bits feed the next shift.
    logic             r_msb_unused;

    assign r_msb_unused = r[WIDTH];

    assign t      = {r[WIDTH-1:0], q_sr[WIDTH-1]};
    assign s      = t - {1'b0, d};
    // Borrow set: trial subtraction failed, keep T and shift in a 0.
    assign next_r = s[WIDTH] ? t : s;
    assign next_q = {q_sr[WIDTH-2:0], ~s[WIDTH]};
    assign last   = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            q_sr   <= '0;
            d      <= '0;
            r      <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        q_sr   <= bus.dividend;
                        d      <= bus.divisor;
                        r      <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        if (bus.divisor == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            quot_q <= '1;
                            rem_q  <= bus.dividend;
                            dbz_q  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r     <= next_r;
                    q_sr  <= next_q;
                    count <= count + 1'b1;
                    if (last) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        quot_q <= next_q;
                        rem_q  <= next_r[WIDTH-1:0];
                        dbz_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
